instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter ALLOW_ZERO_WAIT, default 1; when 1, imem_ack may arrive in the same cycle as imem_req.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the requested word.
REQ-007 imem_ack  input  1  memory response; imem_data valid this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream not ready; holds the issued instruction.
REQ-010 jump  input  2  redirect select: 00 sequential/branch, 01 absolute (j/jal), 10 register (jr/jalr), 11 reserved.
REQ-011 branch_taken  input  1  beq/bne outcome for the issued instruction.
REQ-012 reg_target  input  32  register value for jump=10.
REQ-013 instr  output  32  issued instruction word.
REQ-014 opcode  output  6  instr[31:26].
REQ-015 func  output  6  instr[5:0].
REQ-016 valid  output  1  instr/opcode/func/pc are valid.
REQ-017 pc  output  32  address of the issued instruction.
REQ-018 pc_plus4  output  32  pc + 4, the link value for jal/jalr.
REQ-019 fault  output  1  sticky misaligned-target or reserved-jump flag.

Function
REQ-020 The FSM SHALL have four states: FETCH, WAIT, ISSUE, HALT.
REQ-021 FETCH: imem_req=1, imem_addr=pc; on imem_ack (when ALLOW_ZERO_WAIT=1) capture imem_data and go to ISSUE, else go to WAIT.
REQ-022 WAIT: imem_req=1 and imem_addr SHALL remain stable until imem_ack; on imem_ack capture imem_data and go to ISSUE.
REQ-023 ISSUE: valid=1, imem_req=0; instr, opcode, func and pc SHALL hold while stall=1.
REQ-024 Consume SHALL occur in a cycle with valid=1 and stall=0; jump, branch_taken and reg_target are sampled only in that cycle.
REQ-025 On consume the next pc SHALL be selected as follows:
- jump=01: {pc_plus4[31:28], instr[25:0], 2'b00}.
- jump=10: reg_target.
- jump=00, branch_taken=1: pc_plus4 + {sext(instr[15:0]), 2'b00}.
- otherwise: pc_plus4.
REQ-026 On consume the FSM SHALL return to FETCH; the issue-to-next-request latency is 1 cycle.
REQ-027 jump SHALL take priority over branch_taken when jump is non-zero.
REQ-028 Address arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000 with no fault.
REQ-029 On consume with jump=10 and reg_target[1:0]!=0, or with jump=11, the block SHALL set fault=1, leave pc unchanged, and go to HALT.
REQ-030 HALT: valid=0, imem_req=0; the block SHALL stay in HALT until reset.
REQ-031 imem_ack outside FETCH/WAIT SHALL be ignored.
REQ-032 valid SHALL be 0 in FETCH, WAIT and HALT.

Reset
REQ-033 When rst_n=0 the block SHALL immediately go to FETCH with pc=RESET_PC, instr=0, valid=0, fault=0, and imem_req=0 while rst_n is low.
REQ-034 A reset during WAIT SHALL abandon the request; an imem_ack arriving after reset release SHALL be accepted only for the RESET_PC request.
REQ-035 After rst_n rises, imem_req SHALL assert on the first clock edge with imem_addr=RESET_PC.

Verification
REQ-036 Sequential, zero-wait: ack every request with data 32'h2008_0005 (addi), stall=0 -> pc sequence 0,4,8,C, valid for one cycle out of every two.
REQ-037 Wait states: ack 3 cycles late -> imem_addr stable for 4 cycles, valid rises the cycle after ack, opcode=6'h08.
REQ-038 Branch: pc=32'h10, instr=32'h1000_FFFE, jump=00, branch_taken=1 -> next imem_addr=32'h0C; with branch_taken=0 -> 32'h14.
REQ-039 Jumps: pc=32'h4000_0000, instr=32'h0800_0010 (j), jump=01 -> next fetch at 32'h4000_0040; jump=10, reg_target=32'h80 -> 32'h80; reg_target=32'h82 -> fault=1, HALT, no further imem_req.
REQ-040 Stall and reset: stall=1 for 5 cycles in ISSUE -> outputs constant, no imem_req; assert rst_n=0 mid-WAIT -> imem_req drops without a clock edge, and after release the first fetch is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory, issues
// them downstream with handshake-based consume, and computes the next pc
// for sequential, branch, absolute-jump and register-jump flow.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FETCH | request at pc (req held low the first cycle after reset)
// S_WAIT  | request outstanding, address held until imem_ack
// S_ISSUE | instruction valid, held while stall=1
// S_HALT  | misaligned target or reserved jump seen, idle until reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          ALLOW_ZERO_WAIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        fault_q;
  logic        req_q;

  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] pc_d;
  logic        redirect_bad;

  // Next-pc selection; jump overrides branch, misaligned jr and the reserved
  // encoding are flagged instead of redirecting.
  always_comb begin
    pc_plus4_w   = pc_q + 32'd4;
    br_off       = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    pc_d         = pc_plus4_w;
    redirect_bad = 1'b0;
    case (jump)
      2'b01: pc_d = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      2'b10: begin
        pc_d         = reg_target;
        redirect_bad = (reg_target[1:0] != 2'b00);
      end
      2'b11: redirect_bad = 1'b1;
      default: begin
        if (branch_taken) pc_d = pc_plus4_w + br_off;
      end
    endcase
  end

  // Fetch/issue sequencer with registered request, valid and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // A request is only live once req_q is high, so an ack left over
          // from before reset cannot be mistaken for the RESET_PC response.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack && ALLOW_ZERO_WAIT) begin
            instr_q <= imem_data;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_data;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            valid_q <= 1'b0;
            if (redirect_bad) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign func      = instr_q[5:0];
  assign valid     = valid_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_w;
  assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential, wait-state, stall, branch,
// jump, wrap, fault and reset scenarios with hand-computed expectations.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic [1:0]  jump;
  logic        branch_taken;
  logic [31:0] reg_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .RESET_PC       (32'h0000_0000),
    .ALLOW_ZERO_WAIT(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .jump        (jump),
    .branch_taken(branch_taken),
    .reg_target  (reg_target),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .valid       (valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge so outputs are settled
  // and newly driven inputs are seen by the next rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From FETCH with a live request: zero-wait ack, lands in ISSUE.
  task automatic fetch_issue(input logic [31:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    cyc();
    imem_ack  = 1'b0;
  endtask

  // From ISSUE: present redirect controls for the consume cycle.
  task automatic consume(input logic [1:0] j, input logic bt, input logic [31:0] rt);
    jump         = j;
    branch_taken = bt;
    reg_target   = rt;
    stall        = 1'b0;
    cyc();
    jump         = 2'b00;
    branch_taken = 1'b0;
    reg_target   = 32'h0;
  endtask

  initial begin
    logic [31:0] held_instr;
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_data    = 32'h0;
    stall        = 1'b0;
    jump         = 2'b00;
    branch_taken = 1'b0;
    reg_target   = 32'h0;
    cyc();
    cyc();

    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, valid},    32'h0);
    chk("rst_fault", {31'h0, fault},    32'h0);
    chk("rst_pc",    pc,                32'h0);
    chk("rst_instr", instr,             32'h0);

    rst_n = 1'b1;
    cyc();
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         32'h0);

    // Sequential zero-wait: every request acked, valid every other cycle.
    imem_ack  = 1'b1;
    imem_data = 32'h2008_0005;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("seq_valid",    {31'h0, valid},    32'h1);
      chk("seq_pc",       pc,                32'(i * 4));
      chk("seq_req_iss",  {31'h0, imem_req}, 32'h0);
      chk("seq_instr",    instr,             32'h2008_0005);
      cyc();
      chk("seq_valid_lo", {31'h0, valid},    32'h0);
      chk("seq_next",     imem_addr,         32'((i + 1) * 4));
    end

    // Wait states: address held four request cycles, ack on the fourth.
    imem_ack = 1'b0;
    chk("ws_addr0", imem_addr, 32'h10);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("ws_req",   {31'h0, imem_req}, 32'h1);
      chk("ws_addr",  imem_addr,         32'h10);
      chk("ws_valid", {31'h0, valid},    32'h0);
    end
    imem_ack  = 1'b1;
    imem_data = 32'h2008_0005;
    stall     = 1'b1;
    cyc();
    imem_ack  = 1'b0;
    chk("ws_valid_rise", {31'h0, valid},  32'h1);
    chk("ws_opcode",     {26'h0, opcode}, 32'h08);
    chk("ws_func",       {26'h0, func},   32'h05);
    chk("ws_pc",         pc,              32'h10);
    chk("ws_pc4",        pc_plus4,        32'h14);

    // Stall: issued instruction held, no new request, stray ack ignored.
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    for (int s = 0; s < 5; s++) begin
      cyc();
      chk("st_valid", {31'h0, valid},    32'h1);
      chk("st_instr", instr,             32'h2008_0005);
      chk("st_pc",    pc,                32'h10);
      chk("st_req",   {31'h0, imem_req}, 32'h0);
    end
    imem_ack = 1'b0;
    consume(2'b10, 1'b0, 32'h10);
    chk("jr_back_addr", imem_addr, 32'h10);

    // Branch taken: 0x14 + (-2 << 2) = 0x0C.
    fetch_issue(32'h1000_FFFE);
    chk("br_opcode", {26'h0, opcode}, 32'h04);
    chk("br_func",   {26'h0, func},   32'h3E);
    consume(2'b00, 1'b1, 32'h0);
    chk("br_taken_addr", imem_addr,         32'h0C);
    chk("br_taken_req",  {31'h0, imem_req}, 32'h1);
    fetch_issue(32'h0000_0000);
    consume(2'b10, 1'b0, 32'h10);
    fetch_issue(32'h1000_FFFE);
    consume(2'b00, 1'b0, 32'h0);
    chk("br_not_taken_addr", imem_addr, 32'h14);

    // Absolute jump, with branch_taken also set to show jump priority.
    fetch_issue(32'h0);
    consume(2'b10, 1'b0, 32'h4000_0000);
    chk("jr_hi_addr", imem_addr, 32'h4000_0000);
    fetch_issue(32'h0800_0010);
    consume(2'b01, 1'b1, 32'h0);
    chk("j_addr", imem_addr, 32'h4000_0040);
    fetch_issue(32'h0);
    consume(2'b10, 1'b0, 32'h80);
    chk("jr_addr", imem_addr, 32'h80);

    // Wrap at the top of the address space.
    fetch_issue(32'h0);
    consume(2'b10, 1'b0, 32'hFFFF_FFFC);
    fetch_issue(32'h0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    consume(2'b00, 1'b0, 32'h0);
    chk("wrap_addr",  imem_addr,      32'h0);
    chk("wrap_fault", {31'h0, fault}, 32'h0);

    // Misaligned register target: fault, pc kept, halted.
    fetch_issue(32'h0);
    consume(2'b10, 1'b0, 32'h82);
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_pc",    pc,             32'h0);
    imem_ack = 1'b1;
    for (int h = 0; h < 3; h++) begin
      cyc();
      chk("halt_req",   {31'h0, imem_req}, 32'h0);
      chk("halt_valid", {31'h0, valid},    32'h0);
      chk("halt_fault", {31'h0, fault},    32'h1);
    end
    imem_ack = 1'b0;

    // Reset mid-WAIT drops the request without a clock edge.
    rst_n = 1'b0;
    cyc();
    chk("rst2_fault", {31'h0, fault}, 32'h0);
    rst_n = 1'b1;
    cyc();
    fetch_issue(32'h0);
    consume(2'b10, 1'b0, 32'h100);
    chk("pre_wait_addr", imem_addr, 32'h100);
    cyc();
    chk("in_wait_req", {31'h0, imem_req}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'h0, imem_req}, 32'h0);
    chk("async_pc",  pc,                32'h0);
    imem_ack  = 1'b1;
    imem_data = 32'hCAFE_0000;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_req",   {31'h0, imem_req}, 32'h1);
    chk("rel_addr",  imem_addr,         32'h0);
    chk("rel_valid", {31'h0, valid},    32'h0);
    chk("rel_instr", instr,             32'h0);

    // Reserved jump encoding faults as well.
    fetch_issue(32'h2008_0005);
    held_instr = instr;
    chk("res_instr", held_instr, 32'h2008_0005);
    consume(2'b11, 1'b0, 32'h0);
    chk("res_fault", {31'h0, fault},    32'h1);
    chk("res_req",   {31'h0, imem_req}, 32'h0);
    chk("res_pc",    pc,                32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
